// File: rtl/alu_decode_stage_pkg.sv
// Shared operation types for the decode stage and the ALU: operation codes,
// RV32I opcode constants and the decoded-entry record carried through the buffer.
package alu_decode_stage_pkg;

  typedef enum logic [3:0] {
    OP_ADD                            = 4'd0,
    OP_SUB                            = 4'd1,
    OP_LEFT_SHIFT_UNSIGNED            = 4'd2,
    OP_LESS_THAN_SIGNED               = 4'd3,
    OP_LESS_THAN_UNSIGNED             = 4'd4,
    OP_XOR                            = 4'd5,
    OP_RIGHT_SHIFT_UNSIGNED           = 4'd6,
    OP_RIGHT_SHIFT_SIGNED             = 4'd7,
    OP_OR                             = 4'd8,
    OP_AND                            = 4'd9,
    OP_GREATER_OR_EQUAL_THAN_SIGNED   = 4'd10,
    OP_GREATER_OR_EQUAL_THAN_UNSIGNED = 4'd11
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // Immediate is kept outside the record because its width follows SIZE.
  typedef struct packed {
    alu_op_e    op;
    logic       alu_src_b_imm;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       branch;
    logic       take_on_zero;
    logic       illegal;
  } decoded_t;

  // Common funct3 mapping of OP and OP-IMM; alt selects SUB / arithmetic shift.
  function automatic alu_op_e funct3_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  funct3_op = alt ? OP_SUB : OP_ADD;
      3'b001:  funct3_op = OP_LEFT_SHIFT_UNSIGNED;
      3'b010:  funct3_op = OP_LESS_THAN_SIGNED;
      3'b011:  funct3_op = OP_LESS_THAN_UNSIGNED;
      3'b100:  funct3_op = OP_XOR;
      3'b101:  funct3_op = alt ? OP_RIGHT_SHIFT_SIGNED : OP_RIGHT_SHIFT_UNSIGNED;
      3'b110:  funct3_op = OP_OR;
      default: funct3_op = OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Upstream instruction handshake plus downstream decoded-entry handshake.
interface alu_decode_stage_if
  import alu_decode_stage_pkg::*;
#(
  parameter int SIZE = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  alu_op_e         operation;
  logic            alu_src_b_imm;
  logic [SIZE-1:0] immediate;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            branch;
  logic            take_on_zero;
  logic            illegal;

  modport master (
    output in_valid, instruction, flush, out_ready,
    input  in_ready, out_valid, operation, alu_src_b_imm, immediate,
           rd, rs1, rs2, branch, take_on_zero, illegal
  );

  modport slave (
    input  in_valid, instruction, flush, out_ready,
    output in_ready, out_valid, operation, alu_src_b_imm, immediate,
           rd, rs1, rs2, branch, take_on_zero, illegal
  );

endinterface

// File: rtl/alu_decode_stage_instr_decoder.sv
// Purely combinational RV32I decode of one instruction word into ALU controls,
// register indices and the extended immediate.
module instr_decoder
  import alu_decode_stage_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [31:0]     instruction_i,
  output decoded_t        decoded_o,
  output logic [SIZE-1:0] immediate_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        funct7_ok;
  logic        funct7_alt;
  logic [31:0] imm32;

  assign opcode     = instruction_i[6:0];
  assign funct3     = instruction_i[14:12];
  assign funct7     = instruction_i[31:25];
  assign funct7_ok  = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
  assign funct7_alt = (funct7 == FUNCT7_ALT);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    decoded_o     = '0;
    decoded_o.op  = OP_ADD;
    decoded_o.rd  = instruction_i[11:7];
    decoded_o.rs1 = instruction_i[19:15];
    decoded_o.rs2 = instruction_i[24:20];
    imm32         = '0;

    case (opcode)
      OPC_OP: begin
        if (!funct7_ok) decoded_o.illegal = 1'b1;
        else            decoded_o.op      = funct3_op(funct3, funct7_alt);
      end
      OPC_OP_IMM: begin
        decoded_o.alu_src_b_imm = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm32 = {27'b0, instruction_i[24:20]};
          if (!funct7_ok) decoded_o.illegal = 1'b1;
          else            decoded_o.op      = funct3_op(funct3, funct7_alt);
        end else begin
          imm32        = {{20{instruction_i[31]}}, instruction_i[31:20]};
          decoded_o.op = funct3_op(funct3, 1'b0);
        end
      end
      OPC_LOAD: begin
        decoded_o.alu_src_b_imm = 1'b1;
        imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
      end
      OPC_STORE: begin
        decoded_o.alu_src_b_imm = 1'b1;
        imm32 = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      end
      OPC_BRANCH: begin
        decoded_o.branch = 1'b1;
        imm32 = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                 instruction_i[30:25], instruction_i[11:8], 1'b0};
        case (funct3)
          3'b000: begin
            decoded_o.op           = OP_SUB;
            decoded_o.take_on_zero = 1'b1;
          end
          3'b001:  decoded_o.op      = OP_SUB;
          3'b100:  decoded_o.op      = OP_LESS_THAN_SIGNED;
          3'b101:  decoded_o.op      = OP_GREATER_OR_EQUAL_THAN_SIGNED;
          3'b110:  decoded_o.op      = OP_LESS_THAN_UNSIGNED;
          3'b111:  decoded_o.op      = OP_GREATER_OR_EQUAL_THAN_UNSIGNED;
          default: decoded_o.illegal = 1'b1;
        endcase
      end
      default: decoded_o.illegal = 1'b1;
    endcase

    // An undecodable word must look like a harmless non-branch ADD downstream.
    if (decoded_o.illegal) begin
      decoded_o.op            = OP_ADD;
      decoded_o.alu_src_b_imm = 1'b0;
      decoded_o.branch        = 1'b0;
      decoded_o.take_on_zero  = 1'b0;
      imm32                   = '0;
    end
  end

  assign immediate_o = SIZE'($signed(imm32));

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage: decodes at the input, then buffers up to two entries (main,
// skid) so in_ready can come straight from a flop without losing throughput.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_decode_stage_if.slave  bus
);

  decoded_t        in_dec;
  logic [SIZE-1:0] in_imm;

  decoded_t        main_q, main_d, skid_q, skid_d;
  logic [SIZE-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            accept;
  logic            pop;

  instr_decoder #(.SIZE(SIZE)) u_decoder (
    .instruction_i (bus.instruction),
    .decoded_o     (in_dec),
    .immediate_o   (in_imm)
  );

  assign accept = bus.in_valid & in_ready_q & ~bus.flush;
  assign pop    = main_valid_q & bus.out_ready;

  always_comb begin
    main_d       = main_q;
    main_imm_d   = main_imm_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_imm_d   = skid_imm_q;
    skid_valid_d = skid_valid_q;

    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop && skid_valid_q) begin
      main_d       = skid_q;
      main_imm_d   = skid_imm_q;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else if (pop || !main_valid_q) begin
      main_valid_d = accept;
      if (accept) begin
        main_d     = in_dec;
        main_imm_d = in_imm;
      end
    end else if (accept) begin
      // Main is held by a stalled consumer: park the new entry in skid.
      skid_d       = in_dec;
      skid_imm_d   = in_imm;
      skid_valid_d = 1'b1;
    end

    in_ready_d = ~skid_valid_d;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_q       <= '0;
      main_imm_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_q       <= main_d;
      main_imm_q   <= main_imm_d;
    end
  end

  // NOTE: skid payload is never observed without skid_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_q     <= skid_d;
    skid_imm_q <= skid_imm_d;
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = main_valid_q;
  assign bus.operation     = main_q.op;
  assign bus.alu_src_b_imm = main_q.alu_src_b_imm;
  assign bus.immediate     = main_imm_q;
  assign bus.rd            = main_q.rd;
  assign bus.rs1           = main_q.rs1;
  assign bus.rs2           = main_q.rs2;
  assign bus.branch        = main_q.branch;
  assign bus.take_on_zero  = main_q.take_on_zero;
  assign bus.illegal       = main_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed instruction words with
// hand-decoded expectations, stall/skid, flush and asynchronous reset cases.
module tb_alu_decode_stage;
  import alu_decode_stage_pkg::*;

  typedef struct {
    logic [31:0] instr;
    alu_op_e     op;
    logic        srcb;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        br;
    logic        toz;
    logic        ill;
    logic        chk_imm;
    logic        chk_ctl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb_q[$];
  exp_t vec[16];

  alu_decode_stage_if #(.SIZE(32)) bus ();

  alu_decode_stage #(.SIZE(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic exp_t v(input logic [31:0] instr, input alu_op_e op, input logic srcb,
                             input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic br, input logic toz,
                             input logic ill, input logic chk_imm, input logic chk_ctl);
    exp_t e;
    e.instr = instr; e.op = op; e.srcb = srcb; e.imm = imm;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.br = br; e.toz = toz; e.ill = ill;
    e.chk_imm = chk_imm; e.chk_ctl = chk_ctl;
    return e;
  endfunction

  // Unchecked fields are zeroed on both sides before comparing.
  function automatic logic [63:0] pack(input exp_t m, input logic chk_imm, input logic chk_ctl);
    return {9'b0, m.op, chk_ctl ? m.srcb : 1'b0, chk_imm ? m.imm : 32'b0,
            m.rd, m.rs1, m.rs2, m.br, chk_ctl ? m.toz : 1'b0, m.ill};
  endfunction

  // Monitor: every handshake the DUT completes must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output op=%0d rd=%0d imm=%08h", bus.operation, bus.rd, bus.immediate);
        end else begin
          exp_t e, g;
          e = sb_q.pop_front();
          g = v(32'h0, bus.operation, bus.alu_src_b_imm, bus.immediate, bus.rd, bus.rs1,
                bus.rs2, bus.branch, bus.take_on_zero, bus.illegal, 1'b0, 1'b0);
          check($sformatf("decode_%08h", e.instr), pack(g, e.chk_imm, e.chk_ctl),
                pack(e, e.chk_imm, e.chk_ctl));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid until accepted; pushes the expectation at the accepting edge.
  task automatic send(input exp_t e);
    logic rdy;
    int   waited = 0;
    bus.in_valid    = 1'b1;
    bus.instruction = e.instr;
    forever begin
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        sb_q.push_back(e);
        #1;
        break;
      end
      #1;
      waited++;
      if (waited > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout instr=%08h in_ready=%0b", e.instr, bus.in_ready);
        break;
      end
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (sb_q.size() != 0 && waited < 40) begin
      step();
      waited++;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    int c0;
    vec[0]  = v(32'h002081B3, OP_ADD, 0, 32'h0, 3, 1, 2, 0, 0, 0, 0, 1);
    vec[1]  = v(32'h40335293, OP_RIGHT_SHIFT_SIGNED, 1, 32'h3, 5, 6, 3, 0, 0, 0, 1, 1);
    vec[2]  = v(32'hFFF00093, OP_ADD, 1, 32'hFFFFFFFF, 1, 0, 31, 0, 0, 0, 1, 1);
    vec[3]  = v(32'h00209463, OP_SUB, 0, 32'h8, 8, 1, 2, 1, 0, 0, 1, 1);
    vec[4]  = v(32'h0000007F, OP_ADD, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0);
    vec[5]  = v(32'hFFC12283, OP_ADD, 1, 32'hFFFFFFFC, 5, 2, 28, 0, 0, 0, 1, 1);
    vec[6]  = v(32'h0060AA23, OP_ADD, 1, 32'h14, 20, 1, 6, 0, 0, 0, 1, 1);
    vec[7]  = v(32'h409403B3, OP_SUB, 0, 32'h0, 7, 8, 9, 0, 0, 0, 0, 1);
    vec[8]  = v(32'hFE000EE3, OP_SUB, 0, 32'hFFFFFFFC, 29, 0, 0, 1, 1, 0, 1, 1);
    vec[9]  = v(32'h0041F863, OP_GREATER_OR_EQUAL_THAN_UNSIGNED, 0, 32'h10, 16, 3, 4, 1, 0, 0, 1, 1);
    vec[10] = v(32'h00002063, OP_ADD, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0);
    vec[11] = v(32'h02208033, OP_ADD, 0, 32'h0, 0, 1, 2, 0, 0, 1, 0, 0);
    vec[12] = v(32'h8005C513, OP_XOR, 1, 32'hFFFFF800, 10, 11, 0, 0, 0, 0, 1, 1);
    vec[13] = v(32'h003150B3, OP_RIGHT_SHIFT_UNSIGNED, 0, 32'h0, 1, 2, 3, 0, 0, 0, 0, 1);
    vec[14] = v(32'h01F21213, OP_LEFT_SHIFT_UNSIGNED, 1, 32'h1F, 4, 4, 31, 0, 0, 0, 1, 1);
    vec[15] = v(32'h42335293, OP_ADD, 0, 32'h0, 5, 6, 3, 0, 0, 1, 0, 0);

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.instruction = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;

    // Values held during reset.
    repeat (2) @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_operation", bus.operation, OP_ADD);
    check("reset_immediate", bus.immediate, 0);
    check("reset_other_outputs", {bus.alu_src_b_imm, bus.rd, bus.rs1, bus.rs2,
                                  bus.branch, bus.take_on_zero, bus.illegal}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;

    // Latency: visible exactly one cycle after acceptance.
    @(negedge clk);
    check("idle_out_valid", bus.out_valid, 0);
    step();
    send(vec[0]);
    idle();
    @(negedge clk);
    check("latency_one", bus.out_valid, 1);
    step();
    drain();

    // Back-to-back stream with out_ready high: one accept per cycle.
    c0 = cyc;
    for (int i = 1; i < 16; i++) send(vec[i]);
    check("throughput_cycles", cyc - c0, 15);
    idle();
    drain();

    // Stall: two accepted, third held by in_ready=0, then all three in order.
    bus.out_ready = 1'b0;
    send(vec[1]);
    send(vec[3]);
    fork
      send(vec[9]);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready_low", bus.in_ready, 0);
          check("stall_out_valid", bus.out_valid, 1);
        end
        step();
        bus.out_ready = 1'b1;
      end
    join
    idle();
    drain();

    // Flush with both entries full and a same-cycle input.
    bus.out_ready = 1'b0;
    send(vec[2]);
    send(vec[5]);
    bus.in_valid = 1'b1;
    bus.instruction = vec[6].instr;
    bus.flush = 1'b1;
    sb_q.delete();
    step();
    bus.flush = 1'b0;
    idle();
    @(negedge clk);
    check("flush_full_out_valid", bus.out_valid, 0);
    check("flush_full_in_ready", bus.in_ready, 1);
    step();
    bus.out_ready = 1'b1;
    repeat (4) step();

    // Flush with only main full while the input could otherwise be accepted.
    bus.out_ready = 1'b0;
    send(vec[7]);
    bus.in_valid = 1'b1;
    bus.instruction = vec[8].instr;
    bus.flush = 1'b1;
    sb_q.delete();
    step();
    bus.flush = 1'b0;
    idle();
    @(negedge clk);
    check("flush_half_out_valid", bus.out_valid, 0);
    check("flush_half_in_ready", bus.in_ready, 1);
    step();
    bus.out_ready = 1'b1;
    repeat (4) step();
    send(vec[12]);
    idle();
    drain();

    // Asynchronous reset mid-stream discards both entries without a clock edge.
    bus.out_ready = 1'b0;
    send(vec[13]);
    send(vec[14]);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", bus.out_valid, 0);
    check("async_reset_in_ready", bus.in_ready, 1);
    check("async_reset_operation", bus.operation, OP_ADD);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    repeat (3) step();
    send(vec[4]);
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
